// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master: FSM states, the host command record,
// and the register numbers also used by the k-means register file.
package apb_master_pkg;

    localparam int CMD_ADDR_W = 8;
    localparam int CMD_DATA_W = 91;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

    // The master forwards any address; these names exist so host code and the
    // register file agree on the numbering.
    typedef enum logic [CMD_ADDR_W-1:0] {
        REG_INTERNAL_STATUS = 8'd0,
        REG_GO              = 8'd1,
        REG_CENT_1          = 8'd2,
        REG_CENT_2          = 8'd3,
        REG_CENT_3          = 8'd4,
        REG_CENT_4          = 8'd5,
        REG_CENT_5          = 8'd6,
        REG_CENT_6          = 8'd7,
        REG_CENT_7          = 8'd8,
        REG_CENT_8          = 8'd9,
        REG_RAM_ADDR        = 8'd10,
        REG_RAM_DATA        = 8'd11,
        REG_FIRST_RAM_ADDR  = 8'd12,
        REG_LAST_RAM_ADDR   = 8'd13
    } reg_num_e;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Host command/response handshake plus the APB bus, bundled for the master.
interface apb_cmd_master_if #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 91
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [addrWidth-1:0] cmd_addr;
    logic [dataWidth-1:0] cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_write;
    logic [dataWidth-1:0] rsp_rdata;
    logic                 rsp_err;

    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [addrWidth-1:0] paddr;
    logic [dataWidth-1:0] pwdata;
    logic [dataWidth-1:0] prdata;
    logic                 pready;

    logic                 busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready,
        input  busy
    );

endinterface

// File: rtl/apb_cmd_master_fifo.sv
// Synchronous circular FIFO holding pending host commands; head is visible
// combinationally and registered by the consumer when it pops.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Full comes from the registered count only, so a same-cycle pop never
    // opens a slot for a push.
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_reg];

endmodule

// File: rtl/apb_cmd_master.sv
// APB initiator: drains queued host commands into APB transfers, one response
// per command, with an ACCESS-phase timeout so a silent slave cannot hang the host.
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int addrWidth  = 8,
    parameter int dataWidth  = 91,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_cmd_master_if.master    bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                 write;
        logic [addrWidth-1:0] addr;
        logic [dataWidth-1:0] wdata;
    } xfer_t;

    state_e               state_reg, state_next;
    xfer_t                xfer_reg;
    logic [TMO_W-1:0]     tmo_reg, tmo_next;
    logic                 rsp_write_reg;
    logic [dataWidth-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic                 rsp_err_reg, rsp_err_next;
    logic                 rsp_load;

    xfer_t                push_entry;
    xfer_t                fifo_head;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 apb_active;

    assign push_entry = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

    cmd_fifo #(
        .WIDTH ($bits(xfer_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.cmd_valid),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next     = state_reg;
        tmo_next       = tmo_reg;
        fifo_pop       = 1'b0;
        rsp_load       = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = '0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                tmo_next   = '0;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                tmo_next = tmo_reg + 1'b1;
                // pready is checked first so a completion on the final
                // allowed cycle still counts as success.
                if (bus.pready) begin
                    rsp_load       = 1'b1;
                    rsp_rdata_next = xfer_reg.write ? '0 : bus.prdata;
                    state_next     = ST_RESP;
                end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                    rsp_load     = 1'b1;
                    rsp_err_next = 1'b1;
                    state_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            tmo_reg       <= '0;
            xfer_reg      <= '0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tmo_reg   <= tmo_next;
            if (fifo_pop) begin
                xfer_reg <= fifo_head;
            end
            if (rsp_load) begin
                rsp_write_reg <= xfer_reg.write;
                rsp_rdata_reg <= rsp_rdata_next;
                rsp_err_reg   <= rsp_err_next;
            end
        end
    end

    // APB outputs are forced to zero whenever no transfer is on the bus.
    assign apb_active  = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
    assign bus.psel    = apb_active;
    assign bus.penable = (state_reg == ST_ACCESS);
    assign bus.pwrite  = apb_active && xfer_reg.write;
    assign bus.paddr   = apb_active ? xfer_reg.addr  : '0;
    assign bus.pwdata  = apb_active ? xfer_reg.wdata : '0;

    assign bus.cmd_ready = !fifo_full;
    assign bus.rsp_valid = (state_reg == ST_RESP);
    assign bus.rsp_write = rsp_write_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.busy      = (fifo_count != '0) || (state_reg != ST_IDLE);

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB initiator that turns a queue of host register commands into APB write/read transfers toward the k-means register file, and returns one response per command. It sits between the host/stub sequencer and the register file's APB port, buffering up to FIFO_DEPTH commands and enforcing a per-transfer timeout so a non-responding slave (e.g. one ignoring APB while GO is set) cannot hang the host.

## Interface
- addrWidth, 8, APB address width
- dataWidth, 91, APB data width
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TIMEOUT, 16, max ACCESS cycles before abort (≥2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  addrWidth  register number
- cmd_wdata  in  dataWidth  write data
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  host accepts response
- rsp_write  out  1  echo of command type
- rsp_rdata  out  dataWidth  read data (0 for writes/errors)
- rsp_err  out  1  transfer timed out
- psel, penable, pwrite  out  1  APB control
- paddr  out  addrWidth  APB address
- pwdata  out  dataWidth  APB write data
- prdata  in  dataWidth  APB read data
- pready  in  1  APB ready
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Push on cmd_valid && cmd_ready; {write, addr, wdata} stored in order. cmd_ready derived from registered count only; push blocked when full even if a pop occurs that cycle.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if FIFO non-empty, pop head into transfer register, go SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, paddr/pwrite/pwdata from transfer register; go ACCESS.
- ACCESS: psel=1, penable=1, controls/address/data stable. Timeout counter increments each ACCESS cycle.
  - pready=1 sampled: capture prdata if read (rsp_rdata=0 for write), rsp_err=0, go RESP.
  - counter reaches TIMEOUT without pready: abort, rsp_err=1, rsp_rdata=0, go RESP.
- RESP: psel=penable=0, rsp_valid=1; on rsp_ready go IDLE, rsp_valid drops next cycle.
- Outside SETUP/ACCESS: psel=penable=pwrite=0, paddr/pwdata=0.
- Register map constants (shared with register file): internal_status=0, GO=1, cent_1..cent_8=2..9, RAM_addr=10, RAM_data=11, first_ram_addr=12, last_ram_addr=13. Master does not filter addresses.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, psel=penable=pwrite=0, paddr=0, pwdata=0, busy=0; FIFO emptied, FSM IDLE, counter 0.
- Reset mid-transfer: psel/penable drop on the next edge; in-flight and queued commands discarded, no response issued.
- Command push to SETUP: push at edge N, IDLE pops at N+1, SETUP cycle N+1..N+2.
- Register-file slave returns pready registered: nominal ACCESS = 2 cycles, write latency cmd→rsp_valid = 4 cycles.
- Minimum 2 cycles of psel=0 between transfers (RESP + IDLE), guaranteeing slave's stale pready has cleared before the next SETUP.
- pready during SETUP or while psel=0 is ignored.
- pready in the same cycle the counter hits TIMEOUT: success wins.
- rsp_ready low: FSM stalls in RESP; FIFO keeps accepting until full.

## Structure
- Package apb_master_pkg: FSM state enum, command struct {write, addr, wdata}, register-number enum above (register file imports the same enum).
- Sub-module cmd_fifo: parameterised synchronous FIFO (push/pop/full/empty/count), circular pointers wrapping at FIFO_DEPTH.
- Top: FSM, transfer register, timeout counter, response register.

## Test plan
- Write addr 2, wdata 0x5A -> one SETUP cycle (psel=1, penable=0, paddr=2, pwrite=1), ACCESS until pready, rsp_valid with rsp_err=0, rsp_rdata=0.
- Read addr 2 after above -> pwrite=0 during transfer, rsp_rdata=0x5A, rsp_write=0.
- pready tied 0, TIMEOUT=16 -> psel high exactly 17 cycles (1 SETUP + 16 ACCESS), then rsp_err=1, rsp_rdata=0.
- rsp_ready held 0, push 6 commands -> 1 in flight, 4 queued, cmd_ready low on 6th; release rsp_ready -> 5 responses in order.
- Two back-to-back writes (addr 10 then 11) -> psel low ≥2 cycles between transfers, both rsp_err=0.
- rst asserted during ACCESS with 2 queued -> next edge psel=0, busy=0, no rsp_valid; subsequent write completes normally.
